down_counter_timer: RTL and testbench

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

---
 rtl/down_counter_timer.sv | 77 +++++++
 tb/tb_down_counter_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable 4-bit down-counting timer with -1/-3 steps, one-shot or auto-reload.
// A terminal event (count reaching or crossing zero) pulses tc for one cycle.
module down_counter_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       count_en,
    input  logic [1:0] c,
    input  logic       auto_reload,
    input  logic [3:0] data_in,
    output logic [3:0] count,
    output logic       tc,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] reload_q, reload_d;
    logic       tc_q, tc_d;
    logic [3:0] step_s;

    // c[1] set means hold; otherwise c[0] selects a step of 1 versus 3.
    assign step_s = c[0] ? 4'd1 : 4'd3;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = data_in;
            reload_d = data_in;
            state_d  = (data_in != 4'd0) ? RUN : IDLE;
        end else if (state_q == RUN && count_en && !c[1]) begin
            if (count_q > step_s) begin
                count_d = count_q - step_s;
            end else begin
                // Reaching or crossing zero terminates the run; never wraps.
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = 4'd0;
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            reload_q <= 4'd0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: expected outputs are queued with each
// stimulus step and popped for comparison one time unit after the clock edge.
module tb_down_counter_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic       count_en;
    logic [1:0] c;
    logic       auto_reload;
    logic [3:0] data_in;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    typedef struct {
        logic [3:0] count;
        logic       tc;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_asserts;
    int   n_fail;

    down_counter_timer dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .count_en    (count_en),
        .c           (c),
        .auto_reload (auto_reload),
        .data_in     (data_in),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [3:0] ec, input logic et, input logic eb,
                        input logic ed, input string tag);
        exp_t e;
        e.count = ec;
        e.tc    = et;
        e.busy  = eb;
        e.done  = ed;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        n_asserts++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_asserts++;
            assert (count === e.count) else begin
                n_fail++;
                $error("FAIL %s.count: observed %0d expected %0d", e.tag, count, e.count);
            end
            n_asserts++;
            assert (tc === e.tc) else begin
                n_fail++;
                $error("FAIL %s.tc: observed %b expected %b", e.tag, tc, e.tc);
            end
            n_asserts++;
            assert (busy === e.busy) else begin
                n_fail++;
                $error("FAIL %s.busy: observed %b expected %b", e.tag, busy, e.busy);
            end
            n_asserts++;
            assert (done === e.done) else begin
                n_fail++;
                $error("FAIL %s.done: observed %b expected %b", e.tag, done, e.done);
            end
        end
    endtask

    // Drive one cycle of inputs, queue what must appear after the edge, then check.
    task automatic step(input logic rst_n, input logic ld, input logic en,
                        input logic [1:0] cc, input logic ar, input logic [3:0] din,
                        input logic [3:0] ec, input logic et, input logic eb,
                        input logic ed, input string tag);
        reset       = rst_n;
        load        = ld;
        count_en    = en;
        c           = cc;
        auto_reload = ar;
        data_in     = din;
        push(ec, et, eb, ed, tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        n_asserts   = 0;
        n_fail      = 0;
        reset       = 1'b0;
        load        = 1'b0;
        count_en    = 1'b0;
        c           = 2'b01;
        auto_reload = 1'b0;
        data_in     = 4'd0;

        // Reset state and hold after release.
        step(0, 0, 0, 2'b01, 0, 4'd0, 4'd0, 0, 0, 0, "reset");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd0, 0, 0, 0, "idle_hold");

        // One-shot by 1 from 5.
        step(1, 1, 0, 2'b01, 0, 4'd5, 4'd5, 0, 1, 0, "os_load5");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd4, 0, 1, 0, "os_4");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd3, 0, 1, 0, "os_3");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd2, 0, 1, 0, "os_2");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd1, 0, 1, 0, "os_1");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd0, 1, 0, 1, "os_tc");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd0, 0, 0, 1, "os_done_hold");
        step(1, 0, 1, 2'b00, 1, 4'd0, 4'd0, 0, 0, 1, "os_done_hold2");

        // Crossing zero by 3 from 7: 4, 1, 0 with no wrap.
        step(1, 1, 0, 2'b00, 0, 4'd7, 4'd7, 0, 1, 0, "x3_load7");
        step(1, 0, 1, 2'b00, 0, 4'd0, 4'd4, 0, 1, 0, "x3_4");
        step(1, 0, 1, 2'b00, 0, 4'd0, 4'd1, 0, 1, 0, "x3_1");
        step(1, 0, 1, 2'b00, 0, 4'd0, 4'd0, 1, 0, 1, "x3_tc");

        // Auto-reload from 4 by 3, then one-shot termination once auto_reload drops.
        step(1, 1, 0, 2'b00, 1, 4'd4, 4'd4, 0, 1, 0, "ar_load4");
        step(1, 0, 1, 2'b00, 1, 4'd0, 4'd1, 0, 1, 0, "ar_1a");
        step(1, 0, 1, 2'b00, 1, 4'd0, 4'd4, 1, 1, 0, "ar_rl_a");
        step(1, 0, 1, 2'b00, 1, 4'd0, 4'd1, 0, 1, 0, "ar_1b");
        step(1, 0, 1, 2'b00, 1, 4'd0, 4'd4, 1, 1, 0, "ar_rl_b");
        step(1, 0, 1, 2'b00, 0, 4'd0, 4'd1, 0, 1, 0, "ar_off_1");
        step(1, 0, 1, 2'b00, 0, 4'd0, 4'd0, 1, 0, 1, "ar_off_tc");

        // Load beats decrement; c=1x and count_en=0 hold.
        step(1, 1, 0, 2'b00, 0, 4'd6, 4'd6, 0, 1, 0, "pri_load6");
        step(1, 1, 1, 2'b00, 0, 4'd9, 4'd9, 0, 1, 0, "pri_load9");
        step(1, 0, 1, 2'b11, 0, 4'd0, 4'd9, 0, 1, 0, "hold_c11_a");
        step(1, 0, 1, 2'b11, 0, 4'd0, 4'd9, 0, 1, 0, "hold_c11_b");
        step(1, 0, 1, 2'b11, 0, 4'd0, 4'd9, 0, 1, 0, "hold_c11_c");
        step(1, 0, 1, 2'b10, 0, 4'd0, 4'd9, 0, 1, 0, "hold_c10");
        step(1, 0, 0, 2'b01, 0, 4'd0, 4'd9, 0, 1, 0, "hold_en0");

        // Load at what would be a terminal edge aborts without tc.
        step(1, 0, 1, 2'b00, 0, 4'd0, 4'd6, 0, 1, 0, "abort_6");
        step(1, 0, 1, 2'b00, 0, 4'd0, 4'd3, 0, 1, 0, "abort_3");
        step(1, 1, 1, 2'b00, 0, 4'd8, 4'd8, 0, 1, 0, "abort_load8");

        // Back-to-back terminal events with reload value 1.
        step(1, 1, 0, 2'b01, 1, 4'd1, 4'd1, 0, 1, 0, "b2b_load1");
        step(1, 0, 1, 2'b01, 1, 4'd0, 4'd1, 1, 1, 0, "b2b_a");
        step(1, 0, 1, 2'b01, 1, 4'd0, 4'd1, 1, 1, 0, "b2b_b");
        step(1, 0, 1, 2'b01, 1, 4'd0, 4'd1, 1, 1, 0, "b2b_c");
        step(1, 0, 0, 2'b01, 1, 4'd0, 4'd1, 0, 1, 0, "b2b_pause");

        // Zero load goes to IDLE and ignores enables; DONE exits only on load.
        step(1, 1, 0, 2'b01, 0, 4'd0, 4'd0, 0, 0, 0, "zero_load");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd0, 0, 0, 0, "zero_idle_en");
        step(1, 1, 0, 2'b01, 0, 4'd2, 4'd2, 0, 1, 0, "d_load2");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd1, 0, 1, 0, "d_1");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd0, 1, 0, 1, "d_tc");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd0, 0, 0, 1, "d_hold");
        step(1, 1, 0, 2'b01, 0, 4'd2, 4'd2, 0, 1, 0, "d_reload2");

        // Reset mid-run: no effect until the edge, then IDLE with no tc.
        step(1, 1, 0, 2'b01, 0, 4'd3, 4'd3, 0, 1, 0, "rst_load3");
        reset    = 1'b0;
        count_en = 1'b1;
        load     = 1'b0;
        #2;
        push(4'd3, 0, 1, 0, "rst_before_edge");
        compare();
        step(0, 0, 1, 2'b01, 0, 4'd0, 4'd0, 0, 0, 0, "rst_mid_run");
        step(1, 0, 1, 2'b01, 0, 4'd0, 4'd0, 0, 0, 0, "rst_released");

        // Reset overrides a simultaneous load and a would-be terminal event.
        step(1, 1, 0, 2'b01, 0, 4'd1, 4'd1, 0, 1, 0, "rst2_load1");
        step(0, 1, 1, 2'b01, 0, 4'd9, 4'd0, 0, 0, 0, "rst2_over_load");
        step(1, 0, 1, 2'b01, 1, 4'd0, 4'd0, 0, 0, 0, "rst2_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
